// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 bus constants, FSM states
// and DDRAM address helpers for the LCD path.
package lcd_pkg;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0] BLANK = 8'h20;
  localparam int         CELLS = 32;

  localparam logic [7:0] FUNC_8B_2L = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_INC  = 8'h06;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SWEEP,
    S_BUSY
  } state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] db;
  } bus_t;

  function automatic logic [6:0] ac_step(
    input logic [6:0] ac,
    input logic       inc
  );
    logic [6:0] r;
    r = inc ? ac + 7'd1 : ac - 7'd1;
    if (inc && ac == LINE1_END) r = LINE2_BASE;
    if (inc && ac == LINE2_END) r = LINE1_BASE;
    if (!inc && ac == LINE1_BASE) r = LINE2_END;
    if (!inc && ac == LINE2_BASE) r = LINE1_END;
    return r;
  endfunction

  function automatic logic ac_shown(input logic [6:0] ac);
    return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] ac_cell(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  function automatic logic ac_legal(input logic [6:0] ac);
    return (ac <= LINE1_END) ||
           (ac >= LINE2_BASE && ac <= LINE2_END);
  endfunction

  // one-hot of the highest set bit; zero when b is zero
  function automatic logic [7:0] top_bit(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_ddram_2x16.sv
// lcd_ddram_2x16: 32x8 visible DDRAM cells, one write
// port and two registered read ports.
module lcd_ddram_2x16
  import lcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic [4:0] rb_addr,
  output logic [7:0] rb_data
);

  logic [7:0] mem [CELLS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= BLANK;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= BLANK;
      rb_data <= BLANK;
    end else begin
      rd_data <= mem[rd_addr];
      rb_data <= mem[rb_addr];
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: display-side HD44780 bus model
// with DDRAM image, address counter and busy timing.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES      = 2000,
  parameter int BUSY_LONG_CYCLES = 82000,
  parameter int BUSY_W           = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_is_data,
  output logic       protocol_err
);

  logic              e_s1;
  logic              e_s2;
  logic              e_d;
  logic              e_fall;
  bus_t              bus;
  state_t            state;
  state_t            state_nx;
  logic [BUSY_W-1:0] cnt;
  logic [BUSY_W-1:0] cnt_nx;
  logic [4:0]        swp;
  logic [4:0]        swp_nx;
  logic              txn_rs;
  logic [7:0]        txn_db;
  logic [7:0]        hb;
  logic [6:0]        ac;
  logic              id;
  logic              we;
  logic [4:0]        waddr;
  logic [7:0]        wdata;
  logic [7:0]        rb_data;

  // bus fields follow E while it is high, then hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e_s1 <= 1'b0;
      e_s2 <= 1'b0;
      e_d  <= 1'b0;
      bus  <= '0;
    end else begin
      e_s1 <= lcd_e;
      e_s2 <= e_s1;
      e_d  <= e_s2;
      if (lcd_e) bus <= '{rs: lcd_rs, rw: lcd_rw, db: lcd_db_in};
    end
  end

  assign e_fall = e_d & ~e_s2;
  assign hb     = top_bit(txn_db);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      swp   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      swp   <= swp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    swp_nx   = swp;
    unique case (state)
      S_IDLE: begin
        if (e_fall && !bus.rw) state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (!txn_rs && hb[0]) begin
          state_nx = S_SWEEP;
          swp_nx   = '0;
        end else begin
          state_nx = S_BUSY;
          cnt_nx   = (!txn_rs && hb[1]) ?
                     BUSY_W'(BUSY_LONG_CYCLES - 1) :
                     BUSY_W'(BUSY_CYCLES - 1);
        end
      end
      S_SWEEP: begin
        if (swp == 5'd31) begin
          state_nx = S_BUSY;
          cnt_nx   = BUSY_W'(BUSY_LONG_CYCLES - 1);
        end else begin
          swp_nx = swp + 5'd1;
        end
      end
      S_BUSY: begin
        if (cnt == '0) state_nx = S_IDLE;
        else cnt_nx = cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txn_rs       <= 1'b0;
      txn_db       <= '0;
      ac           <= '0;
      id           <= 1'b1;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= '0;
      cmd_is_data  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (e_fall) begin
        if (state == S_IDLE) begin
          if (!bus.rw) begin
            txn_rs      <= bus.rs;
            txn_db      <= bus.db;
            cmd_valid   <= 1'b1;
            cmd_byte    <= bus.db;
            cmd_is_data <= bus.rs;
          end else if (bus.rs) begin
            ac <= ac_step(ac, id);
          end
        end else if (!bus.rw) begin
          protocol_err <= 1'b1;
        end
      end
      if (state == S_EXEC) begin
        if (txn_rs) begin
          ac <= ac_step(ac, id);
        end else begin
          unique case (1'b1)
            hb[7]: begin
              ac <= txn_db[6:0];
              if (!ac_legal(txn_db[6:0])) protocol_err <= 1'b1;
            end
            hb[6]: ;
            hb[5]: begin
              if (!txn_db[4] || !txn_db[3]) protocol_err <= 1'b1;
            end
            hb[4]: begin
              if (!txn_db[3]) ac <= ac_step(ac, txn_db[2]);
            end
            hb[3]: begin
              display_on <= txn_db[2];
              cursor_on  <= txn_db[1];
              blink_on   <= txn_db[0];
            end
            hb[2]: id <= txn_db[1];
            hb[1]: ac <= '0;
            default: ;
          endcase
        end
      end
      if (state == S_SWEEP && swp == 5'd31) begin
        ac <= '0;
        id <= 1'b1;
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = ac_cell(ac);
    wdata = txn_db;
    if (state == S_SWEEP) begin
      we    = 1'b1;
      waddr = swp;
      wdata = BLANK;
    end else if (state == S_EXEC && txn_rs && ac_shown(ac)) begin
      we = 1'b1;
    end
  end

  assign lcd_db_oe = e_s2 & bus.rw;

  // hidden addresses read back as blanks
  always_comb begin
    lcd_db_out = '0;
    if (lcd_db_oe) begin
      if (bus.rs) lcd_db_out = ac_shown(ac) ? rb_data : BLANK;
      else lcd_db_out = {busy, ac};
    end
  end

  lcd_ddram_2x16 u_ddram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rb_addr (ac_cell(ac)),
    .rb_data (rb_data)
  );

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed bus transactions
// checked against a behavioural display model.
module tb_lcd_hd44780_responder;

  localparam int BC = 50;
  localparam int BL = 200;
  localparam logic [7:0] INIT [7] =
    '{8'h38, 8'h38, 8'h38, 8'h38, 8'h01, 8'h0C, 8'h06};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_in;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       display_on;
  logic       cursor_on;
  logic       blink_on;
  logic       busy;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_is_data;
  logic       protocol_err;

  always #5 clk = ~clk;

  lcd_hd44780_responder #(
    .BUSY_CYCLES      (BC),
    .BUSY_LONG_CYCLES (BL),
    .BUSY_W           (17)
  ) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_db_in    (lcd_db_in),
    .lcd_db_out   (lcd_db_out),
    .lcd_db_oe    (lcd_db_oe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .busy         (busy),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .cmd_is_data  (cmd_is_data),
    .protocol_err (protocol_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_busy = 0;
  bit chk_en = 0;

  logic [7:0] mem_m [128];
  logic [6:0] ac_m;
  logic       id_m, d_m, c_m, b_m, err_m;
  int         bs, dur, last_fall;
  logic [7:0] q_byte [$];
  logic       q_rs [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return (c >= bs) && (c < bs + dur);
  endfunction

  // address counter as a position on an 80-cell ring
  function automatic logic [6:0] m_step(input logic [6:0] a,
                                        input logic up);
    int p;
    p = (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
    p = up ? (p + 1) % 80 : (p + 79) % 80;
    return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
  endfunction

  function automatic bit m_shown(input logic [6:0] a);
    return (a < 7'h10) || (a >= 7'h40 && a < 7'h50);
  endfunction

  function automatic logic [7:0] m_cell(input int i);
    return (i < 16) ? mem_m[i] : mem_m[64 + i - 16];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h20;
    ac_m = '0; id_m = 1; d_m = 0; c_m = 0; b_m = 0; err_m = 0;
    bs = -1000; dur = 0; last_fall = -1000;
    q_byte.delete(); q_rs.delete();
  endtask

  task automatic apply(input logic rs, input logic [7:0] db);
    dur = 1 + BC;
    if (rs) begin
      if (m_shown(ac_m)) mem_m[ac_m] = db;
      ac_m = m_step(ac_m, id_m);
    end else if (db >= 8'h80) begin
      ac_m = db[6:0];
      if (!(ac_m <= 7'h27 || (ac_m >= 7'h40 && ac_m <= 7'h67)))
        err_m = 1;
    end else if (db >= 8'h40) begin
    end else if (db >= 8'h20) begin
      if (!db[4] || !db[3]) err_m = 1;
    end else if (db >= 8'h10) begin
      if (!db[3]) ac_m = m_step(ac_m, db[2]);
    end else if (db >= 8'h08) begin
      d_m = db[2]; c_m = db[1]; b_m = db[0];
    end else if (db >= 8'h04) begin
      id_m = db[1];
    end else if (db >= 8'h02) begin
      ac_m = '0;
      dur = 1 + BL;
    end else if (db == 8'h01) begin
      for (int i = 0; i < 128; i++) mem_m[i] = 8'h20;
      ac_m = '0; id_m = 1;
      dur = 1 + 32 + BL;
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] db);
    int k;
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 0; lcd_db_in = db; lcd_e = 1;
    repeat (6) @(negedge clk);
    lcd_e = 0;
    k = cyc;
    last_fall = k;
    if (m_busy(k + 2)) begin
      err_m = 1;
    end else begin
      bs = k + 3;
      q_byte.push_back(db);
      q_rs.push_back(rs);
      apply(rs, db);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic rs, output logic [7:0] v,
                    output int c);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1; lcd_e = 1;
    repeat (4) @(negedge clk);
    v = lcd_db_out;
    c = cyc;
    check("read_oe", lcd_db_oe, 1);
    lcd_e = 0;
    if (rs && !m_busy(cyc + 2)) ac_m = m_step(ac_m, id_m);
    repeat (4) @(negedge clk);
  endtask

  task automatic settle();
    while (cyc < bs + dur + 2) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_bf(input string nm, input logic [7:0] lit);
    logic [7:0] v;
    int c;
    rd(1'b0, v, c);
    check({nm, "_model"}, v, {m_busy(c), ac_m});
    check(nm, v, lit);
  endtask

  task automatic chk_data_rd(input string nm, input logic [7:0] lit);
    logic [7:0] v, e;
    int c;
    e = m_shown(ac_m) ? mem_m[ac_m] : 8'h20;
    rd(1'b1, v, c);
    check({nm, "_model"}, v, e);
    check(nm, v, lit);
  endtask

  task automatic chk_cell(input int i, input logic [7:0] lit);
    @(negedge clk);
    rd_addr = 5'(i);
    @(negedge clk);
    check($sformatf("cell%0d_model", i), rd_data, m_cell(i));
    check($sformatf("cell%0d", i), rd_data, lit);
  endtask

  always @(negedge clk) begin
    int c;
    bit eb;
    if (chk_en && reset_n) begin
      c = cyc;
      eb = m_busy(c);
      check("busy", busy, eb);
      check("cmd_valid", cmd_valid, c == bs);
      if (cmd_valid) begin
        n_cmd++;
        if (q_byte.size() == 0) begin
          check("cmd_unexpected", 1, 0);
        end else begin
          check("cmd_byte", cmd_byte, q_byte.pop_front());
          check("cmd_is_data", cmd_is_data, q_rs.pop_front());
        end
      end
      if (busy) n_busy++;
      if (!eb && c >= last_fall + 4) begin
        check("display_on", display_on, d_m);
        check("cursor_on", cursor_on, c_m);
        check("blink_on", blink_on, b_m);
        check("protocol_err", protocol_err, err_m);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1; lcd_e = 0; lcd_rs = 0; lcd_rw = 0;
    lcd_db_in = 0; rd_addr = 0;
    model_reset();
    #3 reset_n = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_cmd_is_data", cmd_is_data, 0);
    check("rst_err", protocol_err, 0);
    check("rst_flags", {display_on, cursor_on, blink_on}, 0);
    check("rst_oe", lcd_db_oe, 0);
    check("rst_db_out", lcd_db_out, 0);
    check("rst_rd_data", rd_data, 8'h20);
    reset_n = 1;
    chk_en = 1;

    n_cmd = 0;
    for (int i = 0; i < 7; i++) begin
      wr(0, INIT[i]);
      settle();
    end
    check("init_cmds", n_cmd, 7);
    check("init_flags", {display_on, cursor_on, blink_on}, 3'b100);
    check("init_err", protocol_err, 0);
    chk_bf("init_ac", 8'h00);

    for (int i = 0; i < 16; i++) begin
      wr(1, 8'h41 + 8'(i));
      settle();
    end
    wr(0, 8'hC0); settle();
    wr(1, 8'h51); settle();
    for (int i = 0; i < 16; i++) chk_cell(i, 8'h41 + 8'(i));
    chk_cell(16, 8'h51);
    chk_bf("text_ac", 8'h41);
    wr(0, 8'h80); settle();
    chk_data_rd("data_read", 8'h41);
    chk_bf("read_ac", 8'h01);

    wr(0, 8'hA7); settle();
    wr(1, 8'h58); settle();
    chk_bf("wrap_up_ac", 8'h40);
    chk_cell(16, 8'h51);
    wr(0, 8'h04); settle();
    wr(0, 8'h80); settle();
    wr(1, 8'h59); settle();
    chk_cell(0, 8'h59);
    chk_bf("wrap_dn_ac", 8'h67);
    wr(0, 8'h14); settle();
    chk_bf("shift_ac", 8'h00);
    wr(0, 8'h06); settle();

    wr(0, 8'h0F);
    repeat (10) @(negedge clk);
    wr(0, 8'h08);
    chk_bf("bf_while_busy", {1'b1, 7'h00});
    settle();
    check("viol_err", protocol_err, 1);
    check("viol_flags", {display_on, cursor_on, blink_on}, 3'b111);

    wr(0, 8'hC5); settle();
    n_busy = 0;
    wr(0, 8'h01);
    rd_addr = 5'd16;
    while (cyc < last_fall + 40) @(negedge clk);
    check("sweep_cell16", rd_data, 8'h20);
    check("sweep_busy", busy, 1);
    settle();
    check("clear_busy_len", n_busy, 1 + 32 + BL);
    chk_bf("clear_ac", 8'h00);
    for (int i = 0; i < 32; i++) chk_cell(i, 8'h20);

    wr(0, 8'hCF); settle();
    wr(1, 8'h5A); settle();
    chk_cell(31, 8'h5A);
    wr(0, 8'h01);
    while (cyc < last_fall + 15) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    chk_en = 0;
    #2 reset_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", protocol_err, 0);
    check("mid_rst_flags", {display_on, cursor_on, blink_on}, 0);
    check("mid_rst_cmd", {cmd_valid, cmd_is_data, cmd_byte}, 0);
    check("mid_rst_bus", {lcd_db_oe, lcd_db_out}, 0);
    check("mid_rst_rd_data", rd_data, 8'h20);
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk_en = 1;
    chk_cell(31, 8'h20);
    chk_bf("post_rst_ac", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
